// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: opcodes, ALU control word, FSM states
// and the opcode -> ALU control decode table.
package alu_sequencer_pkg;

    localparam int NUM_REGS = 4;

    typedef enum logic [3:0] {
        OP_PASS  = 4'h0,
        OP_INC   = 4'h1,
        OP_ADD   = 4'h2,
        OP_ADDC  = 4'h3,
        OP_SUB   = 4'h4,
        OP_DEC   = 4'h5,
        OP_AND   = 4'h6,
        OP_OR    = 4'h7,
        OP_XOR   = 4'h8,
        OP_NOTA  = 4'h9,
        OP_SHL   = 4'hA,
        OP_SHR   = 4'hB,
        OP_CLR   = 4'hC,
        OP_NOTB  = 4'hD,
        OP_XNOR  = 4'hE,
        OP_LOADI = 4'hF
    } opcode_e;

    // Arithmetic selects add a second operand (zero, b, ~b, all-ones) plus c_in.
    typedef enum logic [3:0] {
        SEL_ADD_ZERO = 4'h0,
        SEL_ADD_B    = 4'h1,
        SEL_ADD_NOTB = 4'h2,
        SEL_ADD_ONES = 4'h3,
        SEL_AND      = 4'h4,
        SEL_OR       = 4'h5,
        SEL_XOR      = 4'h6,
        SEL_NOTA     = 4'h7,
        SEL_SHL      = 4'h8,
        SEL_SHR      = 4'h9,
        SEL_CLR      = 4'hA,
        SEL_NOTB     = 4'hB,
        SEL_XNOR     = 4'hC
    } alu_sel_e;

    typedef struct packed {
        alu_sel_e sel;
        logic     c_in;
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Decode table. LOADI bypasses the ALU, so its ALU control is don't-care.
    function automatic alu_ctrl_t decode_op(input opcode_e op);
        alu_ctrl_t ctrl;
        ctrl = '{sel: SEL_ADD_ZERO, c_in: 1'b0};
        case (op)
            OP_PASS:  ctrl = '{sel: SEL_ADD_ZERO, c_in: 1'b0};
            OP_INC:   ctrl = '{sel: SEL_ADD_ZERO, c_in: 1'b1};
            OP_ADD:   ctrl = '{sel: SEL_ADD_B,    c_in: 1'b0};
            OP_ADDC:  ctrl = '{sel: SEL_ADD_B,    c_in: 1'b1};
            OP_SUB:   ctrl = '{sel: SEL_ADD_NOTB, c_in: 1'b1};
            OP_DEC:   ctrl = '{sel: SEL_ADD_ONES, c_in: 1'b0};
            OP_AND:   ctrl = '{sel: SEL_AND,      c_in: 1'b0};
            OP_OR:    ctrl = '{sel: SEL_OR,       c_in: 1'b0};
            OP_XOR:   ctrl = '{sel: SEL_XOR,      c_in: 1'b0};
            OP_NOTA:  ctrl = '{sel: SEL_NOTA,     c_in: 1'b0};
            OP_SHL:   ctrl = '{sel: SEL_SHL,      c_in: 1'b0};
            OP_SHR:   ctrl = '{sel: SEL_SHR,      c_in: 1'b0};
            OP_CLR:   ctrl = '{sel: SEL_CLR,      c_in: 1'b0};
            OP_NOTB:  ctrl = '{sel: SEL_NOTB,     c_in: 1'b0};
            OP_XNOR:  ctrl = '{sel: SEL_XNOR,     c_in: 1'b0};
            OP_LOADI: ctrl = '{sel: SEL_ADD_ZERO, c_in: 1'b0};
            default:  ctrl = '{sel: SEL_ADD_ZERO, c_in: 1'b0};
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction and result handshake bundle of the ALU sequencer.
interface alu_sequencer_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [1:0]       in_rd;
    logic [1:0]       in_rs1;
    logic [1:0]       in_rs2;
    logic [WIDTH-1:0] in_imm;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [1:0]       res_rd;
    logic             res_zero;

    // Instruction source / result consumer side.
    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, res_ready,
        input  in_ready, res_valid, res_data, res_rd, res_zero
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, res_ready,
        output in_ready, res_valid, res_data, res_rd, res_zero
    );
endinterface

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU: arithmetic is a + addend + c_in modulo 2^WIDTH,
// the remaining selects are bitwise/shift functions of a and b.
module alu_sequencer_alu
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_ctrl_t        ctrl,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] addend;

    // Choose the second adder operand and produce the selected function.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        addend = '0;
        y      = '0;
        case (ctrl.sel)
            SEL_ADD_B:    addend = b;
            SEL_ADD_NOTB: addend = ~b;
            SEL_ADD_ONES: addend = '1;
            default:      addend = '0;
        endcase
        case (ctrl.sel)
            SEL_ADD_ZERO,
            SEL_ADD_B,
            SEL_ADD_NOTB,
            SEL_ADD_ONES: y = a + addend + WIDTH'(ctrl.c_in);
            SEL_AND:      y = a & b;
            SEL_OR:       y = a | b;
            SEL_XOR:      y = a ^ b;
            SEL_NOTA:     y = ~a;
            SEL_SHL:      y = a << 1;
            SEL_SHR:      y = a >> 1;
            SEL_CLR:      y = '0;
            SEL_NOTB:     y = ~b;
            SEL_XNOR:     y = ~(a ^ b);
            default:      y = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one instruction, executes it against a 4-entry
// register file for one cycle, then holds the result until it is consumed.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic             clk,
    input logic             rst,
    alu_sequencer_if.slave  bus
);

    state_e           state;
    state_e           state_nxt;
    logic             in_ready;
    logic             res_valid;
    logic             accept;

    opcode_e          op_q;
    logic [1:0]       rd_q;
    logic [1:0]       rs1_q;
    logic [1:0]       rs2_q;
    logic [WIDTH-1:0] imm_q;

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] res_data_q;
    logic [1:0]       res_rd_q;

    alu_ctrl_t        alu_ctrl;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] result;

    assign accept   = bus.in_valid && in_ready;
    assign alu_ctrl = decode_op(op_q);
    assign result   = (op_q == OP_LOADI) ? imm_q : alu_y;

    alu_sequencer_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a    (regs[rs1_q]),
        .b    (regs[rs2_q]),
        .ctrl (alu_ctrl),
        .y    (alu_y)
    );

    // FSM state register; reset wins over any handshake in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs, decoded from the current state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Instruction latch, register file write and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register file is small and architecturally must read 0 after reset,
            // so it is built from resettable flops rather than an uninitialised RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            op_q       <= OP_PASS;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
        end else begin
            if (accept) begin
                op_q  <= opcode_e'(bus.in_op);
                rd_q  <= bus.in_rd;
                rs1_q <= bus.in_rs1;
                rs2_q <= bus.in_rs2;
                imm_q <= bus.in_imm;
            end
            // Operands were read before this edge, so rd == rs1/rs2 sees the old value.
            if (state == ST_EXEC) begin
                regs[rd_q] <= result;
                res_data_q <= result;
                res_rd_q   <= rd_q;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data_q;
    assign bus.res_rd    = res_rd_q;
    assign bus.res_zero  = (res_data_q == '0);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: hand sequences for reset, wrap,
// back-pressure and reset-in-flight, plus a table of vectors covering every
// opcode. Expected results go through a scoreboard queue.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int WIDTH = 4;

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [3:0] imm;
        logic [3:0] exp_data;
        int         hold;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic [1:0] rd;
        logic       zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t vecs[21];

    always #5 clk = ~clk;

    alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Issue one instruction from a negedge; returns at the negedge inside EXEC.
    task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [3:0] imm, input logic [3:0] exp_data,
                        input bit push);
        exp_t e;
        check("issue_in_ready", bus.in_ready, 1);
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
        bus.in_valid = 1'b1;
        if (push) begin
            e = '{data: exp_data, rd: rd, zero: (exp_data == 4'd0)};
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble the fields so any failure to latch shows up in the result.
        bus.in_valid = 1'b0;
        bus.in_op    = 4'($urandom);
        bus.in_rd    = 2'($urandom);
        bus.in_rs1   = 2'($urandom);
        bus.in_rs2   = 2'($urandom);
        bus.in_imm   = 4'($urandom);
    endtask

    // Wait for the result, compare it against the scoreboard, optionally
    // apply back-pressure for 'hold' cycles, then consume it.
    task automatic collect(input int hold);
        exp_t e;
        int   n;
        check("exec_res_valid", bus.res_valid, 0);
        check("exec_in_ready", bus.in_ready, 0);
        n = 0;
        while (!bus.res_valid && n < 8) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("latency", n, 1);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: result seen with no expected entry");
            return;
        end
        e = exp_q.pop_front();
        check("res_data", bus.res_data, e.data);
        check("res_rd", bus.res_rd, e.rd);
        check("res_zero", bus.res_zero, e.zero);
        if (hold > 0) begin
            // Offer a LOADI r3,9 that must be ignored while the result is held.
            bus.in_op    = 4'hF;
            bus.in_rd    = 2'd3;
            bus.in_imm   = 4'd9;
            bus.in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
                check("hold_res_valid", bus.res_valid, 1);
                check("hold_in_ready", bus.in_ready, 0);
                check("hold_res_data", bus.res_data, e.data);
                check("hold_res_rd", bus.res_rd, e.rd);
            end
            bus.in_valid = 1'b0;
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_res_valid", bus.res_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Register state is tracked in the comments: r0 r1 r2 r3.
        // After the hand sequences: 0 9 2 0.
        vecs[0]  = '{4'hF, 2'd1, 2'd0, 2'd0, 4'd15,    4'd15,    0}; // LOADI r1=15      -> 0 15 2 0
        vecs[1]  = '{4'h1, 2'd1, 2'd1, 2'd0, 4'd0,     4'd0,     0}; // INC r1 wraps     -> 0 0 2 0
        vecs[2]  = '{4'h0, 2'd0, 2'd1, 2'd0, 4'd0,     4'd0,     0}; // PASS r1 reads 0
        vecs[3]  = '{4'hF, 2'd1, 2'd0, 2'd0, 4'b1010,  4'b1010,  0}; // r1=1010
        vecs[4]  = '{4'hF, 2'd2, 2'd0, 2'd0, 4'b0110,  4'b0110,  0}; // r2=0110
        vecs[5]  = '{4'hE, 2'd0, 2'd1, 2'd2, 4'd0,     4'b0011,  0}; // XNOR -> r0=3
        vecs[6]  = '{4'hB, 2'd3, 2'd1, 2'd0, 4'd0,     4'b0101,  0}; // SHR r1 -> r3=5
        vecs[7]  = '{4'hA, 2'd3, 2'd1, 2'd0, 4'd0,     4'b0100,  0}; // SHL r1 -> r3=4
        vecs[8]  = '{4'h3, 2'd0, 2'd1, 2'd2, 4'd0,     4'd1,     0}; // ADDC 10+6+1 -> r0=1
        vecs[9]  = '{4'h5, 2'd2, 2'd0, 2'd0, 4'd0,     4'd0,     0}; // DEC r0 -> r2=0
        vecs[10] = '{4'h5, 2'd2, 2'd2, 2'd0, 4'd0,     4'd15,    0}; // DEC 0 wraps -> r2=15
        vecs[11] = '{4'h6, 2'd3, 2'd1, 2'd2, 4'd0,     4'd10,    0}; // AND -> r3=10
        vecs[12] = '{4'h7, 2'd0, 2'd0, 2'd3, 4'd0,     4'd11,    0}; // OR 1|10 -> r0=11
        vecs[13] = '{4'h8, 2'd0, 2'd1, 2'd2, 4'd0,     4'd5,     0}; // XOR 1010^1111 -> r0=5
        vecs[14] = '{4'h9, 2'd1, 2'd0, 2'd0, 4'd0,     4'd10,    0}; // NOTA r0 -> r1=10
        vecs[15] = '{4'hD, 2'd1, 2'd0, 2'd3, 4'd0,     4'd5,     0}; // NOTB r3 -> r1=5
        vecs[16] = '{4'hC, 2'd2, 2'd1, 2'd1, 4'd0,     4'd0,     0}; // CLR -> r2=0
        vecs[17] = '{4'h4, 2'd3, 2'd2, 2'd1, 4'd0,     4'd11,    0}; // SUB 0-5 -> r3=11
        vecs[18] = '{4'h2, 2'd3, 2'd3, 2'd3, 4'd0,     4'd6,     0}; // ADD r3+r3 in place -> r3=6
        vecs[19] = '{4'h0, 2'd0, 2'd3, 2'd0, 4'd0,     4'd6,     5}; // PASS r3, held 5 cycles
        vecs[20] = '{4'h0, 2'd1, 2'd3, 2'd0, 4'd0,     4'd6,     0}; // r3 untouched by held LOADI

        bus.in_valid  = 1'b0;
        bus.in_op     = 4'h0;
        bus.in_rd     = 2'd0;
        bus.in_rs1    = 2'd0;
        bus.in_rs2    = 2'd0;
        bus.in_imm    = 4'd0;
        bus.res_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_res_valid", bus.res_valid, 0);
        check("reset_res_data", bus.res_data, 0);
        check("reset_res_rd", bus.res_rd, 0);
        rst = 1'b0;
        @(negedge clk);

        // LOADI r1,5 straight out of reset.
        send(4'hF, 2'd1, 2'd0, 2'd0, 4'd5, 4'd5, 1'b1);
        collect(0);

        // r1=9; ADD wraps to 2; SUB of a register from itself is zero.
        send(4'hF, 2'd1, 2'd0, 2'd0, 4'd9, 4'd9, 1'b1);
        collect(0);
        send(4'h2, 2'd2, 2'd1, 2'd1, 4'd0, 4'd2, 1'b1);
        collect(0);
        send(4'h4, 2'd3, 2'd1, 2'd1, 4'd0, 4'd0, 1'b1);
        collect(0);

        for (int i = 0; i < 21; i++) begin
            send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                 vecs[i].exp_data, 1'b1);
            collect(vecs[i].hold);
        end

        // Reset while LOADI r2,7 is in EXEC: no write, no result.
        send(4'hF, 2'd2, 2'd0, 2'd0, 4'd3, 4'd3, 1'b1);
        collect(0);
        send(4'hF, 2'd2, 2'd0, 2'd0, 4'd7, 4'd7, 1'b0);
        check("pre_reset_exec_res_valid", bus.res_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midreset_in_ready", bus.in_ready, 1);
        check("midreset_res_valid", bus.res_valid, 0);
        check("midreset_res_data", bus.res_data, 0);
        check("midreset_res_rd", bus.res_rd, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("dropped_no_result", bus.res_valid, 0);
        end
        send(4'h0, 2'd0, 2'd2, 2'd0, 4'd0, 4'd0, 1'b1);
        collect(0);
        send(4'h0, 2'd0, 2'd1, 2'd0, 4'd0, 4'd0, 1'b1);
        collect(0);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never seen", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, datapath and register width in bits.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have in_valid  input  1  instruction present.
REQ-005 SHALL have in_ready  output  1  sequencer accepts an instruction this cycle.
REQ-006 SHALL have in_op  input  4  operation code, encoding per REQ-013.
REQ-007 SHALL have in_rd, in_rs1, in_rs2  input  2 each  destination and source register indices.
REQ-008 SHALL have in_imm  input  WIDTH  immediate operand, used only by LOADI.
REQ-009 SHALL have res_valid  output  1  result present.
REQ-010 SHALL have res_ready  input  1  consumer accepts the result.
REQ-011 SHALL have res_data  output  WIDTH, res_rd  output  2, res_zero  output  1  (result, destination index, res_data==0).

Function
REQ-012 SHALL hold a register file of 4 entries of WIDTH bits, r0..r3, all writable.
REQ-013 in_op SHALL map to ALU control {select,c_in}: 0 PASS a; 1 INC a+1; 2 ADD a+b; 3 ADDC a+b+1; 4 SUB a+~b+1; 5 DEC a-1; 6 AND; 7 OR; 8 XOR; 9 NOTA; A SHL a<<1; B SHR a>>1; C CLR 0; D NOTB; E XNOR; F LOADI (result = in_imm, ALU bypassed).
REQ-014 Operand a SHALL be r[rs1], operand b SHALL be r[rs2]; all arithmetic SHALL be modulo 2^WIDTH, carry-out discarded.
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; IDLE->EXEC on in_valid&&in_ready, EXEC->RESP unconditionally, RESP->IDLE on res_valid&&res_ready.
REQ-016 in_ready SHALL be 1 only in IDLE; res_valid SHALL be 1 only in RESP.
REQ-017 On acceptance the instruction fields SHALL be latched; later changes on in_* SHALL have no effect until the next acceptance.
REQ-018 In EXEC the result SHALL be computed from register values current in that cycle and, at the EXEC edge, written to r[rd] and to the res_data/res_rd registers.
REQ-019 Latency: acceptance at edge N SHALL give res_valid=1 in the cycle after edge N+1; minimum issue interval 3 cycles.
REQ-020 rd equal to rs1 or rs2 SHALL read the old value and write the new one (no forwarding needed, no hazard).
REQ-021 While res_valid=1 and res_ready=0, res_data, res_rd, res_zero SHALL remain stable and in_ready SHALL stay 0.
REQ-022 in_valid asserted outside IDLE SHALL be ignored, not queued.
REQ-023 res_zero SHALL be derived from the registered res_data, valid only when res_valid=1.

Reset
REQ-024 rst SHALL, at the next rising edge, force state IDLE, r0..r3=0, res_data=0, res_rd=0, res_valid=0, in_ready=1 after the edge.
REQ-025 rst SHALL take priority over every handshake; an instruction in EXEC or RESP SHALL be dropped with no register write and no result.

Structure
REQ-026 A shared package SHALL hold the 4-bit opcode enumeration, the opcode->{select,c_in} decode table, and the FSM state type.
REQ-027 The block SHALL instantiate the team's existing combinational ALU (WIDTH parameter passed through) as its single sub-module; decode, register file and FSM stay in alu_sequencer.

Verification
REQ-028 Reset then LOADI r1,imm=5 -> in_ready=1 post-reset, res_valid 2 cycles after accept, res_data=5, res_rd=1, res_zero=0.
REQ-029 r1=9: ADD r2=r1+r1 -> res_data=2 (wrap); SUB r3=r1-r1 -> res_data=0, res_zero=1.
REQ-030 Hold res_ready=0 for 5 cycles with in_valid=1 -> res_valid held, res_data stable, in_ready=0, no second instruction accepted.
REQ-031 r1=15: INC r1=r1+1 -> res_data=0, r1 reads 0 on next PASS.
REQ-032 r1=4'b1010, r2=4'b0110: XNOR r0 -> 4'b0011; SHR r1 -> 4'b0101; SHL r1 -> 4'b0100.
REQ-033 rst asserted during EXEC of LOADI r2,imm=7 -> res_valid never asserts, PASS r2 afterwards returns 0.
